xray_sensor_readout: RTL and testbench

Receive side of the x-ray sensor interface: generates the sensor clock and frame-start strobe, samples the sensor's serial pixel output, and assembles it into parallel pixel words. Words are buffered in a small FIFO and presented downstream on a valid/ready handshake. Sits between the sensor pins (SENCLK, SENST, SENDIN) and the pixel-processing or host-transfer logic, all in the 100 MHz CLK domain.

---
 rtl/xray_sensor_readout.sv | 223 ++++++++++++++++++++++
 tb/tb_xray_sensor_readout.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xray_sensor_readout.sv
// Receive side of the x-ray sensor link: generates SENCLK/SENST, deserialises SENDIN into pixel words.
// Latency: a pixel is pushed one CLK after its last bit is sampled; PIX_VALID rises one CLK later.
// Backpressure: PIX_VALID/PIX_READY handshake on a show-ahead FIFO; a push into a full FIFO with no pop is dropped and sets OVERFLOW.
//
// Ports:
//   CLK, RST             system clock, synchronous active-high reset
//   START                frame request, honoured only in IDLE
//   SENDIN               serial pixel data from the sensor, MSB first
//   SENCLK, SENST        sensor clock (idles low) and frame-start strobe
//   BUSY                 frame in progress
//   PIX_DATA, PIX_LAST   FIFO head pixel and its end-of-frame flag
//   PIX_VALID, PIX_READY downstream handshake
//   OVERFLOW             sticky pixel-drop flag, cleared only by RST
module xray_sensor_readout #(
  parameter int CLK_DIV    = 2048,
  parameter int PIXELS     = 64,
  parameter int BITS       = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            SENDIN,
  output logic            SENCLK,
  output logic            SENST,
  output logic            BUSY,
  output logic [BITS-1:0] PIX_DATA,
  output logic            PIX_LAST,
  output logic            PIX_VALID,
  input  logic            PIX_READY,
  output logic            OVERFLOW
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_TC = BW'(BITS - 1);
  localparam logic [PW-1:0] PIX_TC = PW'(PIXELS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DW-1:0]   div_cnt;
  logic            sclk;
  logic [BW-1:0]   bit_cnt;
  logic [PW-1:0]   pix_cnt;
  logic [BITS-1:0] shreg;

  logic            push_vld;
  logic [BITS-1:0] push_dat;
  logic            push_last;

  logic [BITS-1:0]       mem_dat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [BITS-1:0]       hold_dat;
  logic                  ovf;

  logic div_tc;
  logic sclk_fall;
  logic sample;
  logic word_done;
  logic frame_done;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;

  // The divider only runs outside IDLE, so the first SENCLK edge of a
  // frame is always a rising edge CLK_DIV cycles after leaving IDLE.
  assign div_tc     = (state != IDLE) && (div_cnt == DIV_TC);
  assign sclk_fall  = div_tc && sclk;
  // Bits are captured on the high->low transition, giving the sensor a
  // full half-period of setup after it drives on the rising edge.
  assign sample     = (state == SHIFT) && sclk_fall;
  assign word_done  = sample && (bit_cnt == BIT_TC);
  assign frame_done = word_done && (pix_cnt == PIX_TC);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    SENST     = 1'b0;
    BUSY      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        SENST = 1'b1;
        BUSY  = 1'b1;
        // The strobe spans one full SENCLK period and ends on its falling edge.
        if (sclk_fall) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (frame_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------ clock gen + deserialiser
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt   <= '0;
      sclk      <= 1'b0;
      bit_cnt   <= '0;
      pix_cnt   <= '0;
      shreg     <= '0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      push_last <= 1'b0;
    end else begin
      // The finished word is staged for one cycle before entering the FIFO.
      push_vld <= word_done;
      if (word_done) begin
        push_dat  <= {shreg[BITS-2:0], SENDIN};
        push_last <= (pix_cnt == PIX_TC);
      end

      if (state == IDLE) begin
        div_cnt <= '0;
        sclk    <= 1'b0;
        bit_cnt <= '0;
        pix_cnt <= '0;
      end else begin
        if (div_tc) begin
          div_cnt <= '0;
          sclk    <= ~sclk;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end

        if (sample) begin
          shreg <= {shreg[BITS-2:0], SENDIN};
          if (word_done) begin
            bit_cnt <= '0;
            pix_cnt <= frame_done ? '0 : pix_cnt + PW'(1);
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
    end
  end

  assign SENCLK = sclk;

  // ----------------------------------------------------------- pixel FIFO
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign pop        = !fifo_empty && PIX_READY;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push_vld && (!fifo_full || pop);

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_dat[wr_ptr]  <= push_dat;
      mem_last[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold_dat <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop);
      if (!fifo_empty) begin
        hold_dat <= mem_dat[rd_ptr];
      end
      if (push_vld && !push_ok) begin
        ovf <= 1'b1;
      end
    end
  end

  // When empty, PIX_DATA keeps showing the last head so it never shows
  // stale or uninitialised storage.
  assign PIX_DATA  = fifo_empty ? hold_dat : mem_dat[rd_ptr];
  assign PIX_LAST  = !fifo_empty && mem_last[rd_ptr];
  assign PIX_VALID = !fifo_empty;
  assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_xray_sensor_readout.sv
module tb_xray_sensor_readout;

  localparam int CD    = 2;
  localparam int NPIX  = 4;
  localparam int NBITS = 4;
  localparam int DEPTH = 2;

  logic             CLK;
  logic             RST;
  logic             START;
  logic             SENDIN;
  logic             SENCLK;
  logic             SENST;
  logic             BUSY;
  logic [NBITS-1:0] PIX_DATA;
  logic             PIX_LAST;
  logic             PIX_VALID;
  logic             PIX_READY;
  logic             OVERFLOW;

  xray_sensor_readout #(
    .CLK_DIV    (CD),
    .PIXELS     (NPIX),
    .BITS       (NBITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .SENDIN    (SENDIN),
    .SENCLK    (SENCLK),
    .SENST     (SENST),
    .BUSY      (BUSY),
    .PIX_DATA  (PIX_DATA),
    .PIX_LAST  (PIX_LAST),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .OVERFLOW  (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shared between stimulus, sensor model and reference model.
  logic       bitq[$];
  logic [3:0] exp_words[$];
  logic [3:0] got_d[$];
  logic       got_l[$];
  bit         chk_en = 1'b0;
  bit         glitch = 1'b0;
  int         busy_cnt = 0;
  int         rise_cnt = 0;
  int         senst_cnt = 0;

  // ---------------------------------------------------------- sensor model
  // Drives the next bit right after each SENCLK rise outside the strobe.
  // With glitch set it also flips SENDIN just after each fall, which must
  // not disturb the captured bits.
  initial begin
    logic sp;
    SENDIN = 1'b0;
    sp = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (SENCLK && !sp && !SENST && bitq.size() > 0) begin
        SENDIN = bitq.pop_front();
      end else if (glitch && !SENCLK && sp) begin
        SENDIN = ~SENDIN;
      end
      sp = SENCLK;
    end
  end

  // ------------------------------------------------------ reference model
  // Frame timeline from the first BUSY cycle (rel 0): one SENCLK period of
  // strobe, then BITS periods per pixel; pixel p is pushed one cycle after
  // the falling edge that ends its last bit, i.e. at rel = 2*CD*(1+BITS*(p+1)).
  // The FIFO is a plain queue of bounded size.
  logic [3:0] mq_d[$];
  logic       mq_l[$];
  bit         movf = 1'b0;
  int         rel = -1;
  bit         busy_prev = 1'b0;
  bit         sclk_prev = 1'b0;

  always @(negedge CLK) begin
    if (!chk_en) begin
      mq_d.delete();
      mq_l.delete();
      movf = 1'b0;
      rel  = -1;
    end else begin
      chk("pix_valid", PIX_VALID, mq_d.size() != 0);
      if (mq_d.size() != 0) begin
        chk("pix_data", PIX_DATA, mq_d[0]);
        chk("pix_last", PIX_LAST, mq_l[0]);
      end
      chk("overflow", OVERFLOW, movf);
      if (BUSY) busy_cnt++;
      if (SENST) senst_cnt++;
      if (SENCLK && !sclk_prev) rise_cnt++;
      if (BUSY && !busy_prev) rel = 0;
      else if (rel >= 0) rel++;
      if (mq_d.size() != 0 && PIX_READY) begin
        got_d.push_back(mq_d.pop_front());
        got_l.push_back(mq_l.pop_front());
      end
      for (int p = 0; p < NPIX; p++) begin
        if (rel == 2 * CD * (1 + NBITS * (p + 1))) begin
          logic [3:0] w;
          chk("model_word_avail", exp_words.size() > 0, 1);
          w = (exp_words.size() > 0) ? exp_words.pop_front() : 4'h0;
          if (mq_d.size() < DEPTH) begin
            mq_d.push_back(w);
            mq_l.push_back(p == NPIX - 1);
          end else begin
            movf = 1'b1;
          end
        end
      end
    end
    busy_prev = BUSY;
    sclk_prev = SENCLK;
  end

  // ----------------------------------------------------------- vectors
  typedef struct packed {
    logic [15:0] pix;       // pixel 0 in [15:12]
    logic [1:0]  mode;      // 0 ready, 1 stalled, 2 pulsed, 3 random
    logic        glt;
    logic        start_mid;
    logic [2:0]  exp_n;
    logic [15:0] exp_w;
    logic        exp_ovf;
    logic [7:0]  exp_busy;
    logic [4:0]  exp_rise;
    logic [2:0]  exp_senst;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    chk_en    = 1'b0;
    RST       = 1'b1;
    START     = 1'b0;
    PIX_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    bitq.delete();
    exp_words.delete();
    glitch = 1'b0;
    @(posedge CLK);
    #1;
    chk_en = 1'b1;
  endtask

  function automatic logic ready_for(input logic [1:0] mode, input int n);
    case (mode)
      2'd0:    return 1'b1;
      2'd1:    return n >= 69;
      2'd2:    return (n == 52) || (n >= 68);
      default: return (n >= 90) ? 1'b1 : logic'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_frame(input vec_t v, input bit do_tab, input int abort_at);
    int g0, b0, r0, s0;
    g0 = got_d.size();
    b0 = busy_cnt;
    r0 = rise_cnt;
    s0 = senst_cnt;
    for (int i = 0; i < NPIX; i++) begin
      logic [3:0] w;
      w = v.pix[15 - 4 * i -: 4];
      exp_words.push_back(w);
      for (int b = 3; b >= 0; b--) bitq.push_back(w[b]);
    end
    glitch = v.glt;
    START = 1'b1;
    PIX_READY = ready_for(v.mode, -1);
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int n = 0; n < 110; n++) begin
      PIX_READY = ready_for(v.mode, n);
      START = v.start_mid && (n == 30);
      if (n == abort_at) begin
        chk("pre_reset_ovf", OVERFLOW, 1);
        chk_en = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_senclk", SENCLK, 0);
        chk("rst_senst", SENST, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_valid", PIX_VALID, 0);
        chk("rst_ovf", OVERFLOW, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        bitq.delete();
        exp_words.delete();
        glitch = 1'b0;
        @(posedge CLK);
        #1;
        chk_en = 1'b1;
        return;
      end
      if (v.mode == 2'd1 && (n == 52 || n == 53)) begin
        @(negedge CLK);
        chk("ovf_on_third_push", OVERFLOW, n == 53);
      end
      @(posedge CLK);
      #1;
    end
    chk("busy_end", BUSY, 0);
    if (do_tab) begin
      chk("n_deliv", got_d.size() - g0, v.exp_n);
      for (int i = 0; i < int'(v.exp_n); i++) begin
        if (g0 + i < got_d.size()) begin
          chk("word", got_d[g0 + i], v.exp_w[15 - 4 * i -: 4]);
          chk("word_last", got_l[g0 + i], i == NPIX - 1);
        end
      end
      chk("ovf_end", OVERFLOW, v.exp_ovf);
      chk("busy_cycles", busy_cnt - b0, v.exp_busy);
      chk("senclk_rises", rise_cnt - r0, v.exp_rise);
      chk("senst_cycles", senst_cnt - s0, v.exp_senst);
    end
  endtask

  task automatic back_to_back();
    int g0, phase, gap, drain;
    logic [31:0] words;
    words = 32'h1234_5678;
    do_reset();
    g0 = got_d.size();
    for (int i = 0; i < 2 * NPIX; i++) begin
      logic [3:0] w;
      w = words[31 - 4 * i -: 4];
      exp_words.push_back(w);
      for (int b = 3; b >= 0; b--) bitq.push_back(w[b]);
    end
    PIX_READY = 1'b1;
    START = 1'b1;
    phase = 0;
    gap = 0;
    drain = 0;
    for (int n = 0; n < 400 && phase != 4; n++) begin
      @(posedge CLK);
      #1;
      case (phase)
        0: if (BUSY) phase = 1;
        1: if (!BUSY) begin gap++; phase = 2; end
        2: if (!BUSY) gap++; else begin phase = 3; START = 1'b0; end
        default: if (!BUSY) begin drain++; if (drain == 10) phase = 4; end
      endcase
    end
    START = 1'b0;
    chk("b2b_done", phase, 4);
    chk("b2b_gap", gap, 1);
    chk("b2b_n", got_d.size() - g0, 2 * NPIX);
    for (int i = 0; i < 2 * NPIX; i++) begin
      if (g0 + i < got_d.size()) chk("b2b_word", got_d[g0 + i], words[31 - 4 * i -: 4]);
    end
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{pix:16'hA5F0, mode:2'd0, glt:1'b0, start_mid:1'b0, exp_n:3'd4, exp_w:16'hA5F0,
                exp_ovf:1'b0, exp_busy:8'd68, exp_rise:5'd17, exp_senst:3'd4};
    vecs[1] = '{pix:16'hA5F0, mode:2'd1, glt:1'b0, start_mid:1'b0, exp_n:3'd2, exp_w:16'hA500,
                exp_ovf:1'b1, exp_busy:8'd68, exp_rise:5'd17, exp_senst:3'd4};
    vecs[2] = '{pix:16'hA5F0, mode:2'd2, glt:1'b0, start_mid:1'b0, exp_n:3'd4, exp_w:16'hA5F0,
                exp_ovf:1'b0, exp_busy:8'd68, exp_rise:5'd17, exp_senst:3'd4};
    vecs[3] = '{pix:16'h3C96, mode:2'd0, glt:1'b1, start_mid:1'b1, exp_n:3'd4, exp_w:16'h3C96,
                exp_ovf:1'b0, exp_busy:8'd68, exp_rise:5'd17, exp_senst:3'd4};
    vecs[4] = '{pix:16'h1E87, mode:2'd0, glt:1'b0, start_mid:1'b1, exp_n:3'd4, exp_w:16'h1E87,
                exp_ovf:1'b0, exp_busy:8'd68, exp_rise:5'd17, exp_senst:3'd4};

    RST = 1'b1;
    START = 1'b0;
    PIX_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("init_senclk", SENCLK, 0);
    chk("init_senst", SENST, 0);
    chk("init_busy", BUSY, 0);
    chk("init_valid", PIX_VALID, 0);
    chk("init_last", PIX_LAST, 0);
    chk("init_data", PIX_DATA, 0);
    chk("init_ovf", OVERFLOW, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_frame(vecs[i], 1'b1, -1);
    end

    // Overflow is sticky until RST; then a mid-frame reset followed by a clean frame.
    do_reset();
    run_frame(vecs[1], 1'b0, 60);
    run_frame(vecs[0], 1'b1, -1);

    back_to_back();

    for (int k = 0; k < 6; k++) begin
      do_reset();
      rv = vecs[0];
      rv.pix = 16'($urandom);
      rv.mode = 2'd3;
      rv.glt = 1'($urandom_range(0, 1));
      rv.start_mid = 1'($urandom_range(0, 1));
      run_frame(rv, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
